// File: rtl/clm_sbox_sched_if.sv
// Bundle between the S-box scheduler, its requesters and the shared masked S-box.
//   req_valid/req_ready/req_data/req_r : per-requester request channel (slice i = requester i)
//   rsp_valid/rsp_data                 : result strobe (one bit per owner) and result element
//   sbox_in/sbox_r/sbox_drdy_i         : operands and start pulse towards the S-box
//   sbox_drdy_o/sbox_out               : completion pulse and result from the S-box
// Modport slave is the scheduler's view; master is the environment's view.
interface clm_sbox_sched_if #(
  parameter int unsigned D    = 4,
  parameter int unsigned NREQ = 2
);
  localparam int unsigned R  = 8 + D;
  localparam int unsigned RW = 7 * D;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*R-1:0]  req_data;
  logic [NREQ*RW-1:0] req_r;
  logic [NREQ-1:0]    rsp_valid;
  logic [R-1:0]       rsp_data;
  logic [R-1:0]       sbox_in;
  logic [RW-1:0]      sbox_r;
  logic               sbox_drdy_i;
  logic               sbox_drdy_o;
  logic [R-1:0]       sbox_out;

  modport slave (
    input  req_valid, req_data, req_r, sbox_drdy_o, sbox_out,
    output req_ready, rsp_valid, rsp_data, sbox_in, sbox_r, sbox_drdy_i
  );

  modport master (
    output req_valid, req_data, req_r, sbox_drdy_o, sbox_out,
    input  req_ready, rsp_valid, rsp_data, sbox_in, sbox_r, sbox_drdy_i
  );
endinterface

// File: rtl/clm_sbox_sched.sv
// Round-robin scheduler sharing one masked CLM S-box between NREQ requesters
// (0 = round datapath, 1 = key expansion). One byte in flight at a time; a
// watchdog aborts a WAIT that never sees sbox_drdy_o.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : request/response/S-box bundle (clm_sbox_sched_if.slave)
//   busy : scheduler not idle
//   err  : sticky error, timeout or sbox_drdy_o outside WAIT
module clm_sbox_sched #(
  parameter int unsigned D       = 4,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  clm_sbox_sched_if.slave    bus,
  output logic               busy,
  output logic               err
);
  localparam int unsigned R  = 8 + D;
  localparam int unsigned RW = 7 * D;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [R-1:0]    in_q, in_d;
  logic [RW-1:0]   r_q, r_d;
  logic [R-1:0]    rsp_q, rsp_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] rsp_vld;
  logic            drdy_i;
  logic            grant_vld;
  logic [PW-1:0]   grant;
  logic [PW-1:0]   idx;
  int              tmp;

  logic [R-1:0]    data_arr [NREQ];
  logic [RW-1:0]   r_arr    [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign data_arr[gi] = bus.req_data[gi*R +: R];
    assign r_arr[gi]    = bus.req_r[gi*RW +: RW];
  end

  // First valid requester scanning from ptr upwards, wrapping at NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    tmp       = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      tmp = (int'(ptr_q) + k) % int'(NREQ);
      idx = PW'(tmp);
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    in_d    = in_q;
    r_d     = r_q;
    rsp_d   = rsp_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    ready   = '0;
    rsp_vld = '0;
    drdy_i  = 1'b0;

    // A completion pulse outside WAIT has no owner; flag it and drop it.
    if (bus.sbox_drdy_o && (state_q != StWait)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Gating with rst keeps req_ready low while reset is held.
        if (grant_vld && rst) begin
          ready[grant] = 1'b1;
          in_d         = data_arr[grant];
          r_d          = r_arr[grant];
          owner_d      = grant;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        drdy_i  = 1'b1;
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.sbox_drdy_o) begin
          rsp_d   = bus.sbox_out;
          state_d = StDone;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          // Abort without a response; ptr is left alone so nobody loses its turn.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      StDone: begin
        rsp_vld[owner_q] = 1'b1;
        ptr_d            = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
        state_d          = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      in_q    <= '0;
      r_q     <= '0;
      rsp_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      in_q    <= in_d;
      r_q     <= r_d;
      rsp_q   <= rsp_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.rsp_valid   = rsp_vld;
  assign bus.rsp_data    = rsp_q;
  assign bus.sbox_in     = in_q;
  assign bus.sbox_r      = r_q;
  assign bus.sbox_drdy_i = drdy_i;
  assign busy            = (state_q != StIdle);
  assign err             = err_q;
endmodule

// File: tb/tb_clm_sbox_sched.sv
// Bench for clm_sbox_sched: directed scenarios plus a randomized phase, with a
// mock S-box (latency 5, out = in ^ 12'hA5A) and a transaction-level reference
// model (round-robin pick, expected result queue with due cycle).
module tb_clm_sbox_sched;
  localparam int unsigned D       = 4;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned R       = 12;
  localparam int unsigned RW      = 28;
  localparam int          LAT     = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, err;

  always #5 clk = ~clk;

  clm_sbox_sched_if #(.D(D), .NREQ(NREQ)) bus ();

  clm_sbox_sched #(.D(D), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  // Mock S-box, independent of the scheduler reset.
  logic         mock_en   = 1'b1;
  logic         mock_drdy = 1'b0;
  logic [R-1:0] mock_out  = '0;
  logic [R-1:0] mock_hold = '0;
  int           mock_cnt  = 0;
  logic         spur      = 1'b0;

  always @(posedge clk) begin
    mock_drdy <= 1'b0;
    if (mock_cnt != 0) begin
      mock_cnt <= mock_cnt - 1;
      if (mock_cnt == 1) begin
        mock_drdy <= 1'b1;
        mock_out  <= mock_hold ^ 12'hA5A;
      end
    end
    if (bus.sbox_drdy_i && mock_en) begin
      mock_cnt  <= LAT - 1;
      mock_hold <= bus.sbox_in;
    end
  end

  assign bus.sbox_drdy_o = mock_drdy | spur;
  assign bus.sbox_out    = mock_out;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model state.
  typedef struct {
    int           owner;
    logic [R-1:0] data;
    int           due;
  } exp_t;

  exp_t            exp_q[$];
  int              g_log[$];
  int              c_log[$];
  int              m_ptr   = 0;
  int              m_free  = 0;
  int              cyc     = 0;
  int              acc_cyc = -10;
  int              n_rsp   = 0;
  int              m_w;
  logic [NREQ-1:0] m_exp_ready;
  logic [R-1:0]    last_in = '0;
  logic [RW-1:0]   last_r  = '0;
  logic [NREQ-1:0] granted = '0;
  int              mode    = 0;   // 0 manual, 1 continuous, 2 random

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < int'(NREQ); k++) begin
      int i;
      i = (ptr + k) % int'(NREQ);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      m_ptr  = 0;
      m_free = 0;
      exp_q.delete();
    end else begin
      m_w = rr_pick(m_ptr, bus.req_valid);
      m_exp_ready = '0;
      if (cyc >= m_free && m_w >= 0) m_exp_ready[m_w] = 1'b1;
      check("busy", busy, cyc < m_free);
      if (bus.req_ready != 0 || m_exp_ready != 0) check("req_ready", bus.req_ready, m_exp_ready);
      if (m_exp_ready != 0) begin
        granted[m_w] = 1'b1;
        g_log.push_back(m_w);
        c_log.push_back(cyc);
        acc_cyc = cyc;
        last_in = bus.req_data[m_w*R +: R];
        last_r  = bus.req_r[m_w*RW +: RW];
        if (mock_en) begin
          m_free = cyc + 3 + LAT;
          exp_q.push_back('{m_w, last_in ^ 12'hA5A, cyc + 2 + LAT});
        end else begin
          m_free = cyc + 2 + TIMEOUT;
        end
      end
      if (bus.sbox_drdy_i || cyc == acc_cyc + 1) begin
        check("issue_cycle", bus.sbox_drdy_i, cyc == acc_cyc + 1);
        check("sbox_in", bus.sbox_in, last_in);
        check("sbox_r", bus.sbox_r, last_r);
      end
      if (bus.rsp_valid != 0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_owner", bus.rsp_valid, 64'(1) << e.owner);
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_cycle", cyc, e.due);
          m_ptr = (e.owner + 1) % int'(NREQ);
          n_rsp++;
        end
      end else if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_missing", bus.rsp_valid, 64'(1) << e.owner);
        m_ptr = (e.owner + 1) % int'(NREQ);
      end
    end
  end

  task automatic new_item(input int i);
    bus.req_valid[i]          = 1'b1;
    bus.req_data[i*R +: R]    = R'($urandom);
    bus.req_r[i*RW +: RW]     = RW'($urandom);
  endtask

  task automatic apply_reqs();
    for (int i = 0; i < int'(NREQ); i++) begin
      if (granted[i]) begin
        granted[i] = 1'b0;
        if (mode == 1 || (mode == 2 && $urandom_range(1) == 1)) new_item(i);
        else bus.req_valid[i] = 1'b0;
      end else if (mode == 2) begin
        if (!bus.req_valid[i]) begin
          if ($urandom_range(3) == 0) new_item(i);
        end else if ($urandom_range(15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    apply_reqs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    granted = '0;
    tick();
    tick();
    g_log.delete();
    c_log.delete();
    rst = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || exp_q.size() != 0 || bus.req_valid != 0) && n < 200);
    check("wait_idle", n < 200, 1);
  endtask

  task automatic wait_issue(input string tag);
    int found;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      tick();
      #3;
      if (bus.sbox_drdy_i) found = 1;
    end
    check(tag, found, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n0;
    int found;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_r     = '0;

    // Reset state
    tick();
    tick();
    #3;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_drdy_i", bus.sbox_drdy_i, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_sbox_in", bus.sbox_in, 0);
    check("rst_sbox_r", bus.sbox_r, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    rst = 1'b1;

    // Single request, known data
    tick();
    bus.req_valid[0]       = 1'b1;
    bus.req_data[0 +: R]   = 12'h123;
    bus.req_r[0 +: RW]     = 28'h1234567;
    #2;
    check("single_ready", bus.req_ready, 2'b01);
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      tick();
      #3;
      if (k == 1) check("single_drdy_i", bus.sbox_drdy_i, 1);
      if (bus.rsp_valid != 0) lat = k;
    end
    check("single_latency", lat, LAT + 2);
    check("single_rsp_data", bus.rsp_data, 12'hB79);
    wait_idle();

    // Both requesters continuously valid from reset
    mode = 1;
    new_item(0);
    new_item(1);
    do_reset();
    for (int n = 0; n < 100 && g_log.size() < 4; n++) tick();
    mode = 0;
    bus.req_valid = '0;
    check("rr_count", g_log.size(), 4);
    if (g_log.size() >= 4) begin
      for (int k = 0; k < 4; k++) check("rr_owner", g_log[k], k % 2);
      for (int k = 1; k < 4; k++) check("rr_gap", c_log[k] - c_log[k-1], LAT + 3);
    end
    wait_idle();

    // Only requester 1 with ptr=0, then ptr must wrap back to 0
    do_reset();
    tick();
    new_item(1);
    #2;
    check("only1_ready", bus.req_ready, 2'b10);
    wait_idle();
    new_item(0);
    new_item(1);
    #2;
    check("ptr_wrap_ready", bus.req_ready, 2'b01);
    bus.req_valid[1] = 1'b0;
    wait_idle();

    // S-box never answers
    mock_en = 1'b0;
    tick();
    new_item(0);
    wait_issue("timeout_issue");
    repeat (63) tick();
    #3;
    check("timeout_err_early", err, 0);
    check("timeout_busy_early", busy, 1);
    tick();
    #3;
    check("timeout_err_last", err, 0);
    tick();
    #3;
    check("timeout_err", err, 1);
    check("timeout_idle", busy, 0);
    check("timeout_no_rsp", bus.rsp_valid, 0);
    mock_en = 1'b1;
    n0 = n_rsp;
    new_item(0);
    wait_idle();
    check("timeout_recover", n_rsp, n0 + 1);

    // Spurious completion in IDLE
    do_reset();
    tick();
    bus.req_valid[0]     = 1'b1;
    bus.req_data[0 +: R] = 12'h0F0;
    wait_idle();
    check("spur_pre_err", err, 0);
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    #3;
    check("spur_err", err, 1);
    check("spur_busy", busy, 0);
    check("spur_rsp_valid", bus.rsp_valid, 0);
    check("spur_rsp_data", bus.rsp_data, 12'hAAA);
    check("spur_sbox_in", bus.sbox_in, 12'h0F0);

    // Reset two cycles after the start pulse
    tick();
    new_item(1);
    wait_issue("midrst_issue");
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("midrst_req_ready", bus.req_ready, 0);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_drdy_i", bus.sbox_drdy_i, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_sbox_in", bus.sbox_in, 0);
    check("midrst_sbox_r", bus.sbox_r, 0);
    check("midrst_rsp_data", bus.rsp_data, 0);
    tick();
    rst = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      tick();
      #3;
      if (mock_drdy) found = 1;
    end
    check("late_drdy_seen", found, 1);
    tick();
    #3;
    check("late_drdy_err", err, 1);
    check("late_drdy_idle", busy, 0);

    // Randomized traffic
    do_reset();
    n0 = n_rsp;
    mode = 2;
    repeat (600) tick();
    mode = 0;
    bus.req_valid = '0;
    wait_idle();
    check("rand_drain", exp_q.size(), 0);
    check("rand_activity", n_rsp > n0 + 20, 1);
    check("rand_err", err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
